uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised successor UART receiver. It is oversampled by an external baud-tick enable (clken) and has configurable data width, parity, stop bits and oversampling ratio. It adds an input synchroniser, 3-sample majority voting, false-start rejection, parity/framing/overrun status, and break-safe resynchronisation. It sits between the pad-side rx line and the register/FIFO layer, and keeps the rdy/rdy_clr handshake of the existing receiver.

Parameters:
DATA_BITS, 8, payload bits per frame; legal 5..9; LSB first.
OVERSAMPLE, 16, clken ticks per bit; legal 8..16, even.
PARITY_EN, 0, 1 = a parity bit follows the data.
PARITY_ODD, 0, 0 = even parity, 1 = odd; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits checked; legal 1 or 2.

Ports:
clk  in  1  system clock; all state on posedge.
rst_n  in  1  asynchronous active-low reset.
clken  in  1  oversample tick; one clk wide; all FSM/counter updates are qualified by it.
rx  in  1  asynchronous serial input; idle high.
rdy_clr  in  1  one-clk pulse; clears rdy and overrun.
rdy  out  1  frame committed and not yet acknowledged.
data_out  out  DATA_BITS  last committed payload.
parity_err  out  1  parity mismatch on the last committed frame.
frame_err  out  1  a checked stop bit sampled low on the last committed frame.
overrun  out  1  a frame was committed while rdy was still set.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM=IDLE; counters 0; both synchroniser flops 1.
- rx passes through a 2-flop synchroniser (rx_s) on every clk, independent of clken.
- Sample counter: width $clog2(OVERSAMPLE); counts 0..OVERSAMPLE-1 on clken, then wraps to 0. MID = OVERSAMPLE/2.
- Bit value = majority of rx_s at counts MID-1, MID, MID+1. The decision is taken at count MID+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. All transitions occur on clken.
  - IDLE: rx_s=0 -> START, count=1. Otherwise hold, count=0.
  - START: voted bit=1 -> IDLE (false start; no flags, no rdy). voted 0 -> continue. At count wrap -> DATA, bit index=0.
  - DATA: at the decision point shift the voted bit into the shift register at [index]. At wrap, index++. After DATA_BITS bits -> PARITY if PARITY_EN, else STOP.
  - PARITY: at the decision point compute the error. Even: XOR(data, bit) must be 0. Odd: it must be 1. At wrap -> STOP.
  - STOP: at each stop bit's decision point a 0 sets the pending frame error. After the decision point of the LAST stop bit, commit (see below) on that same clken. Then go to IDLE if no framing error, else WAIT_IDLE. Earlier stop bits finish their full bit before the next one starts.
  - WAIT_IDLE: hold until rx_s=1 on a clken, then IDLE. This prevents a break condition from re-triggering frames.
- Commit (one clk, on clken): data_out <= shift register; parity_err and frame_err <= pending values; rdy <= 1.
  - overrun <= 1 if rdy was 1 and rdy_clr is 0 in that cycle. Once set, overrun stays 1 until rdy_clr.
- Latency: rdy rises the clk after the clken carrying the last stop-bit decision. This is about half a bit earlier than a full-stop-bit design, which allows baud mismatch of up to ~±3% at OVERSAMPLE=16.
- rdy_clr: clears rdy and overrun next clk. It does not require clken. parity_err, frame_err and data_out are kept until the next commit.
- rdy_clr in the same cycle as a commit: the commit wins. rdy=1; overrun is not set, and any existing overrun is cleared.
- Pending error flags reset at START entry.
- Reset mid-frame: immediate return to the reset state; the partial frame is discarded.
- clken continuously high is legal (OVERSAMPLE clk per bit). clken low freezes the FSM; only the synchroniser and rdy_clr act.

Decomposition:
- Shared package uart_pkg: FSM state encoding (3-bit localparams), parity-mode constants (PAR_EVEN=0, PAR_ODD=1), legal-range limits for DATA_BITS and OVERSAMPLE. The TX successor uses the same package.
- Sub-module uart_rx_sync: 2-flop synchroniser with reset value 1 and parameter STAGES (default 2).
- Majority vote, counters and FSM stay in uart_rx_param.
- Parameter legality is checked by elaboration-time assertions.

Test Plan:
- Defaults (8N1, OVERSAMPLE=16, clken every 4 clk); send 0xA5 -> rdy=1, data_out=0xA5, parity_err=0, frame_err=0, overrun=0.
- PARITY_EN=1, PARITY_ODD=0; send 0x3C with parity bit 1 -> rdy=1, data_out=0x3C, parity_err=1. Repeat with parity bit 0 -> parity_err=0.
- Stop bit held low and rx kept low for 20 bit times after it -> one frame, frame_err=1; no further rdy until rx returns high and a new start bit arrives.
- Frames 0x11 then 0x22 with no rdy_clr -> data_out=0x22, overrun=1. Pulse rdy_clr -> rdy=0, overrun=0, data_out still 0x22.
- rx low for 3 clken ticks then high (glitch) -> no rdy, FSM back in IDLE. Single-tick inversion at count MID inside a data bit -> byte still received correctly.
- DATA_BITS=7, STOP_BITS=2, with rst_n pulsed low in the middle of bit 4 -> all outputs 0 immediately; the next frame 0x55 is received cleanly with data_out=7'h55.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes, parameter limits, vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned DATA_BITS_MIN  = 5;
  localparam int unsigned DATA_BITS_MAX  = 9;
  localparam int unsigned OVERSAMPLE_MIN = 8;
  localparam int unsigned OVERSAMPLE_MAX = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx pin; resets to idle-high.
module uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  if (STAGES < 2) begin : g_bad_stages
    $error("uart_rx_sync: STAGES must be at least 2");
  end

  // shift the raw input one stage per clk
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
  end

  // synchroniser register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority vote and status flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clken,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             PAR_MODE  = PARITY_ODD ? PAR_ODD : PAR_EVEN;

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS out of range");
  end
  if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_param: OVERSAMPLE must be even and in range");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  logic rx_s;

  uart_rx_sync #(.STAGES(2)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (rx),
    .sync_out (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 samp0_q, samp0_d;
  logic                 samp1_q, samp1_d;
  logic                 par_pend_q, par_pend_d;
  logic                 frm_pend_q, frm_pend_d;
  logic                 rdy_q, rdy_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic                 vote;
  logic                 is_dec;
  logic                 is_wrap;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 commit;
  logic                 frm_commit;

  // next-state logic: sampling, bit timing, frame sequencing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    samp0_d    = samp0_q;
    samp1_d    = samp1_q;
    par_pend_d = par_pend_q;
    frm_pend_d = frm_pend_q;
    commit     = 1'b0;
    frm_commit = frm_pend_q;

    vote    = maj3(samp0_q, samp1_q, rx_s);
    is_dec  = (cnt_q == CNT_DEC);
    is_wrap = (cnt_q == CNT_LAST);
    cnt_inc = is_wrap ? '0 : cnt_q + CNT_W'(1);

    if (clken) begin
      if (cnt_q == CNT_S0) samp0_d = rx_s;
      if (cnt_q == CNT_S1) samp1_d = rx_s;

      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d    = ST_START;
            cnt_d      = CNT_W'(1);
            par_pend_d = 1'b0;
            frm_pend_d = 1'b0;
          end
        end
        ST_START: begin
          cnt_d = cnt_inc;
          if (is_dec && vote) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (is_wrap) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end
        ST_DATA: begin
          cnt_d = cnt_inc;
          if (is_dec) shift_d[idx_q] = vote;
          if (is_wrap) begin
            if (idx_q == IDX_LAST) begin
              idx_d      = '0;
              stop_idx_d = 1'b0;
              state_d    = PARITY_EN ? ST_PARITY : ST_STOP;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        ST_PARITY: begin
          cnt_d = cnt_inc;
          if (is_dec) par_pend_d = (^shift_q) ^ vote ^ PAR_MODE;
          if (is_wrap) begin
            state_d    = ST_STOP;
            stop_idx_d = 1'b0;
          end
        end
        ST_STOP: begin
          cnt_d = cnt_inc;
          if (is_dec) begin
            if (!vote) frm_pend_d = 1'b1;
            // last stop bit commits at its decision point, not at bit end
            if (stop_idx_q == STOP_LAST) begin
              commit     = 1'b1;
              frm_commit = frm_pend_q | ~vote;
              cnt_d      = '0;
              state_d    = (frm_pend_q || !vote) ? ST_WAIT_IDLE : ST_IDLE;
            end
          end else if (is_wrap) begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          cnt_d = '0;
          if (rx_s) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // output register updates: commit has priority over rdy_clr
  always_comb begin
    rdy_d  = rdy_q;
    data_d = data_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
    if (commit) begin
      rdy_d  = 1'b1;
      data_d = shift_q;
      perr_d = PARITY_EN ? par_pend_q : 1'b0;
      ferr_d = frm_commit;
      ovr_d  = rdy_clr ? 1'b0 : (ovr_q | rdy_q);
    end else if (rdy_clr) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      samp0_q    <= 1'b1;
      samp1_q    <= 1'b1;
      par_pend_q <= 1'b0;
      frm_pend_q <= 1'b0;
      rdy_q      <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      samp0_q    <= samp0_d;
      samp1_q    <= samp1_d;
      par_pend_q <= par_pend_d;
      frm_pend_q <= frm_pend_d;
      rdy_q      <= rdy_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rdy        = rdy_q;
  assign data_out   = data_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: three configurations (8N1, 8E1, 7N2) on shared clk/clken.
module tb_uart_rx_param;

  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clken = 1'b0;
  logic [1:0] cyc = 2'd0;
  logic rx_line = 1'b1;
  int sel = 0;

  int checks = 0;
  int errors = 0;

  logic d8_rx, pe_rx, d7_rx;
  logic d8_clr = 1'b0, pe_clr = 1'b0, d7_clr = 1'b0;
  logic d8_rdy, d8_perr, d8_ferr, d8_ovr;
  logic pe_rdy, pe_perr, pe_ferr, pe_ovr;
  logic d7_rdy, d7_perr, d7_ferr, d7_ovr;
  logic [7:0] d8_dout, pe_dout;
  logic [6:0] d7_dout;

  assign d8_rx = (sel == 0) ? rx_line : 1'b1;
  assign pe_rx = (sel == 1) ? rx_line : 1'b1;
  assign d7_rx = (sel == 2) ? rx_line : 1'b1;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_d8 (
    .clk(clk), .rst_n(rst_n), .clken(clken), .rx(d8_rx), .rdy_clr(d8_clr), .rdy(d8_rdy),
    .data_out(d8_dout), .parity_err(d8_perr), .frame_err(d8_ferr), .overrun(d8_ovr));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_pe (
    .clk(clk), .rst_n(rst_n), .clken(clken), .rx(pe_rx), .rdy_clr(pe_clr), .rdy(pe_rdy),
    .data_out(pe_dout), .parity_err(pe_perr), .frame_err(pe_ferr), .overrun(pe_ovr));

  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_d7 (
    .clk(clk), .rst_n(rst_n), .clken(clken), .rx(d7_rx), .rdy_clr(d7_clr), .rdy(d7_rdy),
    .data_out(d7_dout), .parity_err(d7_perr), .frame_err(d7_ferr), .overrun(d7_ovr));

  always #5 clk = ~clk;

  // clken: one clk high out of every four, changed on negedge
  always @(negedge clk) begin
    cyc   <= cyc + 2'd1;
    clken <= (cyc == 2'd3);
  end

  logic d8_rdy_prev = 1'b0;
  int d8_rises = 0;
  always @(posedge clk) begin
    d8_rdy_prev <= d8_rdy;
    if (d8_rdy && !d8_rdy_prev) d8_rises <= d8_rises + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // reference: parity error iff total count of ones disagrees with the selected mode
  function automatic logic model_perr(input logic [8:0] data, input int nbits, input int pbit, input bit odd);
    int ones;
    ones = pbit;
    for (int i = 0; i < nbits; i++) ones += int'(data[i]);
    return (ones % 2) != (odd ? 1 : 0);
  endfunction

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!clken && n < 16);
    if (!clken) begin
      checks++;
      errors++;
      $display("FAIL tick_wait got no clken exp clken within 16 clk");
    end
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    rx_line = v;
    repeat (n) wait_tick();
  endtask

  task automatic send_frame(input int nbits, input logic [8:0] data, input int pbit,
                            input logic [1:0] stops, input int nstops, input int idle_bits);
    rx_line = 1'b1;
    wait_tick();
    drive(1'b0, OS);
    for (int i = 0; i < nbits; i++) drive(data[i], OS);
    if (pbit >= 0) drive(pbit[0], OS);
    for (int i = 0; i < nstops; i++) drive(stops[i], OS);
    drive(1'b1, idle_bits * OS);
  endtask

  task automatic pulse_clr(input int which);
    case (which)
      0: d8_clr = 1'b1;
      1: pe_clr = 1'b1;
      default: d7_clr = 1'b1;
    endcase
    @(posedge clk);
    #1;
    d8_clr = 1'b0;
    pe_clr = 1'b0;
    d7_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({d8_rdy, d8_dout, d8_perr, d8_ferr, d8_ovr} !== 12'h000) begin
      errors++;
      $display("FAIL reset_d8 got %h exp 000", {d8_rdy, d8_dout, d8_perr, d8_ferr, d8_ovr});
    end
    checks++;
    if ({pe_rdy, pe_dout, pe_perr, pe_ferr, pe_ovr} !== 12'h000) begin
      errors++;
      $display("FAIL reset_pe got %h exp 000", {pe_rdy, pe_dout, pe_perr, pe_ferr, pe_ovr});
    end
    checks++;
    if ({d7_rdy, d7_dout, d7_perr, d7_ferr, d7_ovr} !== 11'h000) begin
      errors++;
      $display("FAIL reset_d7 got %h exp 000", {d7_rdy, d7_dout, d7_perr, d7_ferr, d7_ovr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) wait_tick();
  endtask

  task automatic test_basic();
    sel = 0;
    send_frame(8, 9'h0A5, -1, 2'b11, 1, 1);
    checks++;
    if ({d8_rdy, d8_dout, d8_perr, d8_ferr, d8_ovr} !== {1'b1, 8'hA5, 3'b000}) begin
      errors++;
      $display("FAIL basic_a5 got rdy=%b data=%h pe=%b fe=%b ov=%b exp 1 a5 0 0 0",
               d8_rdy, d8_dout, d8_perr, d8_ferr, d8_ovr);
    end
    pulse_clr(0);
    checks++;
    if (d8_rdy !== 1'b0 || d8_dout !== 8'hA5) begin
      errors++;
      $display("FAIL basic_clr got rdy=%b data=%h exp 0 a5", d8_rdy, d8_dout);
    end
  endtask

  task automatic test_parity();
    logic [8:0] data;
    int pb;
    sel = 1;
    send_frame(8, 9'h03C, 1, 2'b11, 1, 1);
    checks++;
    if ({pe_rdy, pe_dout, pe_perr, pe_ferr} !== {1'b1, 8'h3C, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL parity_3c_p1 got rdy=%b data=%h pe=%b fe=%b exp 1 3c 1 0", pe_rdy, pe_dout, pe_perr, pe_ferr);
    end
    pulse_clr(1);
    send_frame(8, 9'h03C, 0, 2'b11, 1, 1);
    checks++;
    if ({pe_rdy, pe_dout, pe_perr, pe_ferr} !== {1'b1, 8'h3C, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL parity_3c_p0 got rdy=%b data=%h pe=%b fe=%b exp 1 3c 0 0", pe_rdy, pe_dout, pe_perr, pe_ferr);
    end
    for (int k = 0; k < 4; k++) begin
      pulse_clr(1);
      data = 9'($urandom_range(0, 255));
      pb = int'($urandom_range(0, 1));
      send_frame(8, data, pb, 2'b11, 1, 1);
      checks++;
      if ({pe_rdy, pe_dout, pe_perr, pe_ovr} !== {1'b1, data[7:0], model_perr(data, 8, pb, 1'b0), 1'b0}) begin
        errors++;
        $display("FAIL parity_rand got rdy=%b data=%h pe=%b ov=%b exp 1 %h %b 0",
                 pe_rdy, pe_dout, pe_perr, pe_ovr, data[7:0], model_perr(data, 8, pb, 1'b0));
      end
    end
    pulse_clr(1);
  endtask

  task automatic test_break();
    int r0;
    logic [8:0] data;
    sel = 0;
    pulse_clr(0);
    r0 = d8_rises;
    data = 9'($urandom_range(0, 255));
    send_frame(8, data, -1, 2'b00, 1, 0);
    drive(1'b0, 20 * OS);
    checks++;
    if (d8_rises - r0 !== 1 || d8_ferr !== 1'b1 || d8_dout !== data[7:0] || d8_ovr !== 1'b0) begin
      errors++;
      $display("FAIL break_one_frame got rises=%0d fe=%b data=%h ov=%b exp 1 1 %h 0",
               d8_rises - r0, d8_ferr, d8_dout, d8_ovr, data[7:0]);
    end
    pulse_clr(0);
    drive(1'b1, 2 * OS);
    checks++;
    if (d8_rdy !== 1'b0 || d8_rises - r0 !== 1) begin
      errors++;
      $display("FAIL break_no_retrigger got rdy=%b rises=%0d exp 0 1", d8_rdy, d8_rises - r0);
    end
    data = 9'($urandom_range(0, 255));
    send_frame(8, data, -1, 2'b11, 1, 1);
    checks++;
    if ({d8_rdy, d8_dout, d8_ferr} !== {1'b1, data[7:0], 1'b0}) begin
      errors++;
      $display("FAIL break_recover got rdy=%b data=%h fe=%b exp 1 %h 0", d8_rdy, d8_dout, d8_ferr, data[7:0]);
    end
    pulse_clr(0);
  endtask

  task automatic test_overrun();
    sel = 0;
    send_frame(8, 9'h011, -1, 2'b11, 1, 1);
    send_frame(8, 9'h022, -1, 2'b11, 1, 1);
    checks++;
    if ({d8_rdy, d8_dout, d8_ovr} !== {1'b1, 8'h22, 1'b1}) begin
      errors++;
      $display("FAIL overrun_set got rdy=%b data=%h ov=%b exp 1 22 1", d8_rdy, d8_dout, d8_ovr);
    end
    pulse_clr(0);
    checks++;
    if ({d8_rdy, d8_dout, d8_ovr} !== {1'b0, 8'h22, 1'b0}) begin
      errors++;
      $display("FAIL overrun_clr got rdy=%b data=%h ov=%b exp 0 22 0", d8_rdy, d8_dout, d8_ovr);
    end
  endtask

  task automatic test_glitch();
    int r0;
    logic [7:0] data;
    sel = 0;
    r0 = d8_rises;
    rx_line = 1'b1;
    wait_tick();
    drive(1'b0, 3);
    drive(1'b1, 12 * OS);
    checks++;
    if (d8_rdy !== 1'b0 || d8_rises !== r0) begin
      errors++;
      $display("FAIL glitch_reject got rdy=%b rises=%0d exp 0 %0d", d8_rdy, d8_rises, r0);
    end
    data = 8'($urandom_range(0, 255));
    rx_line = 1'b1;
    wait_tick();
    drive(1'b0, OS);
    for (int i = 0; i < 8; i++) begin
      drive(data[i], OS / 2);
      drive(~data[i], 1);
      drive(data[i], OS / 2 - 1);
    end
    drive(1'b1, 2 * OS);
    checks++;
    if ({d8_rdy, d8_dout, d8_ferr} !== {1'b1, data, 1'b0}) begin
      errors++;
      $display("FAIL glitch_vote got rdy=%b data=%h fe=%b exp 1 %h 0", d8_rdy, d8_dout, d8_ferr, data);
    end
  endtask

  task automatic test_random();
    logic exp_rdy, exp_ovr, exp_ferr;
    logic [8:0] data;
    logic stop;
    sel = 0;
    pulse_clr(0);
    exp_rdy = 1'b0;
    exp_ovr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        pulse_clr(0);
        exp_rdy = 1'b0;
        exp_ovr = 1'b0;
      end
      data = 9'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(8, data, -1, {1'b1, stop}, 1, 1);
      exp_ovr  = exp_ovr | exp_rdy;
      exp_rdy  = 1'b1;
      exp_ferr = ~stop;
      checks++;
      if ({d8_rdy, d8_dout, d8_perr, d8_ferr, d8_ovr} !== {exp_rdy, data[7:0], 1'b0, exp_ferr, exp_ovr}) begin
        errors++;
        $display("FAIL random_frame got rdy=%b data=%h pe=%b fe=%b ov=%b exp %b %h 0 %b %b",
                 d8_rdy, d8_dout, d8_perr, d8_ferr, d8_ovr, exp_rdy, data[7:0], exp_ferr, exp_ovr);
      end
    end
    pulse_clr(0);
  endtask

  task automatic test_reset_midframe();
    logic [8:0] data;
    sel = 2;
    data = 9'($urandom_range(1, 127));
    send_frame(7, data, -1, 2'b01, 2, 1);
    checks++;
    if ({d7_rdy, d7_dout, d7_ferr, d7_perr} !== {1'b1, data[6:0], 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL d7_second_stop got rdy=%b data=%h fe=%b pe=%b exp 1 %h 1 0", d7_rdy, d7_dout, d7_ferr, d7_perr, data[6:0]);
    end
    data = 9'($urandom_range(0, 127));
    rx_line = 1'b1;
    wait_tick();
    drive(1'b0, OS);
    for (int i = 0; i < 4; i++) drive(data[i], OS);
    drive(data[4], OS / 2);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({d7_rdy, d7_dout, d7_perr, d7_ferr, d7_ovr} !== 11'h000) begin
      errors++;
      $display("FAIL midframe_reset got %h exp 000", {d7_rdy, d7_dout, d7_perr, d7_ferr, d7_ovr});
    end
    rx_line = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) wait_tick();
    send_frame(7, 9'h055, -1, 2'b11, 2, 1);
    checks++;
    if ({d7_rdy, d7_dout, d7_perr, d7_ferr, d7_ovr} !== {1'b1, 7'h55, 3'b000}) begin
      errors++;
      $display("FAIL d7_after_reset got rdy=%b data=%h pe=%b fe=%b ov=%b exp 1 55 0 0 0",
               d7_rdy, d7_dout, d7_perr, d7_ferr, d7_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_overrun();
    test_glitch();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
